// File: rtl/timing_loop_ctrl.sv
// Sequencer for the Gardner timing-recovery loop: IDLE -> FLUSH -> ACQ -> TRACK with a
// windowed |e| lock detector. Define TIMING_LOOP_STATS_EN to add the unlock_cnt_o counter.
module timing_loop_ctrl #(
    parameter int            WE         = 18,
    parameter int            WG         = 16,
    parameter logic [WG-1:0] KP_ACQ     = 16'h0800,
    parameter logic [WG-1:0] KI_ACQ     = 16'h0040,
    parameter logic [WG-1:0] KP_TRK     = 16'h0200,
    parameter logic [WG-1:0] KI_TRK     = 16'h0008,
    parameter int            FLUSH_SYMS = 2,
    parameter int            ACQ_SYMS   = 256,
    parameter int            LOCK_WIN   = 64,
    parameter int            LOCK_THR   = 20000,
    parameter int            UNLOCK_CNT = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            enable_i,
    input  logic signed [WE-1:0]            e_in,
    input  logic                            e_valid_i,
    output logic [WG-1:0]                   kp_o,
    output logic [WG-1:0]                   ki_o,
    output logic                            loop_en_o,
    output logic                            loop_clr_o,
    output logic [1:0]                      state_o,
    output logic                            locked_o,
    output logic [WE-2+$clog2(LOCK_WIN):0]  lock_metric_o
`ifdef TIMING_LOOP_STATS_EN
    ,
    output logic [15:0]                     unlock_cnt_o
`endif
);

    localparam int MW = WE - 1 + $clog2(LOCK_WIN);
    localparam int LW = $clog2(LOCK_WIN);
    localparam int FW = $clog2(FLUSH_SYMS + 1);
    localparam int AW = $clog2(ACQ_SYMS + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_ACQ   = 2'd2;
    localparam logic [1:0] S_TRACK = 2'd3;

    localparam logic [LW-1:0] WIN_LAST   = LW'(LOCK_WIN - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_SYMS - 1);
    localparam logic [AW-1:0] ACQ_MAX    = AW'(ACQ_SYMS);
    localparam logic [BW-1:0] BAD_LAST   = BW'(UNLOCK_CNT - 1);

    logic [1:0]    state;
    logic [FW-1:0] flush_cnt;
    logic [LW-1:0] win_cnt;
    logic [AW-1:0] acq_cnt;
    logic [BW-1:0] bad_cnt;
    logic [MW-1:0] acc;
    logic          good_hist;

    logic [WE-2:0] e_abs;
    logic [MW-1:0] sum;
    logic [AW-1:0] acq_nxt;
    logic          win_end;
    logic          win_good;
    logic          fall_back;

    assign state_o = state;

    always_comb begin
        // most negative error has no positive twin; clamp to the largest magnitude
        if (e_in[WE-1] && (e_in[WE-2:0] == '0))
            e_abs = '1;
        else if (e_in[WE-1])
            e_abs = (WE-1)'(-e_in);
        else
            e_abs = e_in[WE-2:0];
        sum       = acc + MW'(e_abs);
        win_end   = e_valid_i && (win_cnt == WIN_LAST);
        win_good  = 64'(sum) < 64'(LOCK_THR);
        acq_nxt   = (acq_cnt == ACQ_MAX) ? acq_cnt : acq_cnt + AW'(1);
        fall_back = enable_i && (state == S_TRACK) && win_end && !win_good &&
                    (bad_cnt == BAD_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            kp_o          <= '0;
            ki_o          <= '0;
            loop_en_o     <= 1'b0;
            loop_clr_o    <= 1'b1;
            locked_o      <= 1'b0;
            lock_metric_o <= '0;
            flush_cnt     <= '0;
            win_cnt       <= '0;
            acq_cnt       <= '0;
            bad_cnt       <= '0;
            acc           <= '0;
            good_hist     <= 1'b0;
        end else if (!enable_i) begin
            // dropping enable wins over any coincident strobe; the metric is kept
            state      <= S_IDLE;
            kp_o       <= '0;
            ki_o       <= '0;
            loop_en_o  <= 1'b0;
            loop_clr_o <= 1'b1;
            locked_o   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state      <= S_FLUSH;
                    kp_o       <= KP_ACQ;
                    ki_o       <= KI_ACQ;
                    loop_en_o  <= 1'b0;
                    loop_clr_o <= 1'b1;
                    flush_cnt  <= '0;
                end
                S_FLUSH: begin
                    if (e_valid_i) begin
                        if (flush_cnt == FLUSH_LAST) begin
                            state      <= S_ACQ;
                            loop_en_o  <= 1'b1;
                            loop_clr_o <= 1'b0;
                            win_cnt    <= '0;
                            acc        <= '0;
                            acq_cnt    <= '0;
                            bad_cnt    <= '0;
                            good_hist  <= 1'b0;
                        end else begin
                            flush_cnt <= flush_cnt + FW'(1);
                        end
                    end
                end
                default: begin
                    // ACQ and TRACK share the window datapath; also ends a fall-back clear pulse
                    loop_en_o  <= 1'b1;
                    loop_clr_o <= 1'b0;
                    if (e_valid_i) begin
                        if (state == S_ACQ)
                            acq_cnt <= acq_nxt;
                        if (win_end) begin
                            lock_metric_o <= sum;
                            acc           <= '0;
                            win_cnt       <= '0;
                            good_hist     <= win_good;
                        end else begin
                            acc     <= sum;
                            win_cnt <= win_cnt + LW'(1);
                        end
                    end
                    if ((state == S_ACQ) && win_end && win_good && good_hist &&
                        (acq_nxt == ACQ_MAX)) begin
                        state    <= S_TRACK;
                        kp_o     <= KP_TRK;
                        ki_o     <= KI_TRK;
                        locked_o <= 1'b1;
                    end
                    if ((state == S_TRACK) && win_end) begin
                        if (win_good)
                            bad_cnt <= '0;
                        else
                            bad_cnt <= bad_cnt + BW'(1);
                    end
                    if (fall_back) begin
                        state      <= S_ACQ;
                        kp_o       <= KP_ACQ;
                        ki_o       <= KI_ACQ;
                        loop_en_o  <= 1'b0;
                        loop_clr_o <= 1'b1;
                        locked_o   <= 1'b0;
                        win_cnt    <= '0;
                        acc        <= '0;
                        acq_cnt    <= '0;
                        bad_cnt    <= '0;
                        good_hist  <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef TIMING_LOOP_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            unlock_cnt_o <= '0;
        else if (fall_back && (unlock_cnt_o != 16'hFFFF))
            unlock_cnt_o <= unlock_cnt_o + 16'd1;
    end
`endif

endmodule
